// File: rtl/sfp_accum_dump.sv
// rtl/sfp_accum_dump.sv - integrate-and-dump accumulator for signed fixed-point streams
//
// Sums N consecutive accepted input samples at full precision and presents
// the block sum as one wide sample behind a valid/ready output register.
// Input and output share the fractional width; the output integer width
// carries the log2(N) growth, so the running sum can never overflow.
//
// Parameters:
//   N      samples per dump (N >= 1)
//   iniw   input integer bits (sign bit included), inqw input fraction bits
//   outiw  output integer bits (sign bit included), outqw output fraction bits
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_val     input sample, signed iniw.inqw
//   in_valid   input sample valid
//   in_ready   block can accept an input sample this cycle
//   clear      synchronous discard of the partial sum
//   out_val    dumped sum, signed outiw.outqw
//   out_valid  out_val holds an unconsumed sum
//   out_ready  downstream accepts out_val this cycle
//   count      samples accumulated in the current block (0..N-1)

module sfp_accum_dump #(
  parameter int N     = 8,
  parameter int iniw  = 1,
  parameter int inqw  = 7,
  parameter int outiw = 4,
  parameter int outqw = 7
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [iniw+inqw-1:0]                 in_val,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 clear,
  output logic [outiw+outqw-1:0]               out_val,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] count
);

  localparam int inw  = iniw + inqw;
  localparam int outw = outiw + outqw;
  localparam int cw   = (N > 1) ? $clog2(N) : 1;
  localparam logic [cw-1:0] last = cw'(N - 1);

  if (N < 1) begin : g_bad_n
    $error("sfp_accum_dump: N must be at least 1");
  end
  if (outqw != inqw) begin : g_bad_qw
    $error("sfp_accum_dump: outqw must equal inqw");
  end
  if (outiw < iniw + $clog2(N)) begin : g_bad_iw
    $error("sfp_accum_dump: outiw too small to hold the sum of N samples");
  end

  logic signed [outw-1:0] acc;
  logic signed [inw-1:0]  in_s;
  logic signed [outw-1:0] in_ext;
  logic                   accept;
  logic                   dump;
  logic                   at_last;

  assign in_s    = in_val;
  assign in_ext  = outw'(in_s);
  assign at_last = (count == last);

  // Only the block-completing sample needs a free output slot; earlier
  // samples just grow acc and are never stalled by a held output.
  assign in_ready = !rst && !clear && (!at_last || !out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign dump     = accept && at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      out_val   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (clear) begin
        acc   <= '0;
        count <= '0;
      end else if (accept) begin
        if (at_last) begin
          out_val <= acc + in_ext;
          acc     <= '0;
          count   <= '0;
        end else begin
          acc   <= acc + in_ext;
          count <= count + cw'(1);
        end
      end

      // A dump in the consuming cycle reloads the register without a bubble.
      if (dump) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sfp_accum_dump.sv
// tb/tb_sfp_accum_dump.sv - directed and randomized checks for sfp_accum_dump

module tb_sfp_accum_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_val;
  logic        in_valid;
  logic        in_ready;
  logic        clear;
  logic [10:0] out_val;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;

  logic [7:0]  in_val1;
  logic        in_valid1;
  logic        in_ready1;
  logic        clear1;
  logic [10:0] out_val1;
  logic        out_valid1;
  logic        out_ready1;
  logic [0:0]  count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sfp_accum_dump #(.N(8), .iniw(1), .inqw(7), .outiw(4), .outqw(7)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_valid(in_valid), .in_ready(in_ready),
    .clear(clear), .out_val(out_val), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  sfp_accum_dump #(.N(1), .iniw(1), .inqw(7), .outiw(4), .outqw(7)) dut1 (
    .clk(clk), .rst(rst), .in_val(in_val1), .in_valid(in_valid1), .in_ready(in_ready1),
    .clear(clear1), .out_val(out_val1), .out_valid(out_valid1), .out_ready(out_ready1),
    .count(count1)
  );

  task automatic feed(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_val   = v;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_val !== 11'h000 || count !== 3'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b out_val=%h count=%0d in_ready=%b, want 0 000 0 0",
               out_valid, out_val, count, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic_sum;
    out_ready = 1'b1;
    feed(8'h7F, 8);
    checks++;
    if (out_valid !== 1'b1 || out_val !== 11'h3F8 || count !== 3'd0) begin
      errors++;
      $display("FAIL sum_7f: out_valid=%b out_val=%h count=%0d, want 1 3f8 0", out_valid, out_val, count);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sum_7f_pulse: out_valid=%b, want 0", out_valid);
    end
    feed(8'h80, 8);
    checks++;
    if (out_valid !== 1'b1 || out_val !== 11'h400) begin
      errors++;
      $display("FAIL sum_80: out_valid=%b out_val=%h, want 1 400", out_valid, out_val);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_val !== 11'h400) begin
      errors++;
      $display("FAIL sum_80_pulse: out_valid=%b out_val=%h, want 0 400", out_valid, out_val);
    end
  endtask

  task automatic test_backpressure;
    int bad_ready;
    out_ready = 1'b0;
    feed(8'h01, 8);
    checks++;
    if (out_valid !== 1'b1 || out_val !== 11'h008) begin
      errors++;
      $display("FAIL bp_first_sum: out_valid=%b out_val=%h, want 1 008", out_valid, out_val);
    end
    bad_ready = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_val   = 8'h01;
      #1;
      if (in_ready !== 1'b1) bad_ready++;
    end
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL bp_nonfinal_accept: stalled %0d of 7 non-final samples, want 0", bad_ready);
    end
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || count !== 3'd7 || out_valid !== 1'b1 || out_val !== 11'h008) begin
      errors++;
      $display("FAIL bp_stall: in_ready=%b count=%0d out_valid=%b out_val=%h, want 0 7 1 008",
               in_ready, count, out_valid, out_val);
    end
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_val !== 11'h008) begin
      errors++;
      $display("FAIL bp_hold: in_ready=%b out_valid=%b out_val=%h, want 0 1 008", in_ready, out_valid, out_val);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready=%b, want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_val !== 11'h008 || count !== 3'd0) begin
      errors++;
      $display("FAIL bp_second_sum: out_valid=%b out_val=%h count=%0d, want 1 008 0", out_valid, out_val, count);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_clear;
    out_ready = 1'b1;
    feed(8'h05, 3);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL clear_pre_count: count=%0d, want 3", count);
    end
    clear = 1'b1;
    in_valid = 1'b1;
    in_val = 8'h05;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_ready: in_ready=%b, want 0", in_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_count: count=%0d out_valid=%b, want 0 0", count, out_valid);
    end
    feed(8'h01, 8);
    checks++;
    if (out_valid !== 1'b1 || out_val !== 11'h008) begin
      errors++;
      $display("FAIL clear_sum: out_valid=%b out_val=%h, want 1 008", out_valid, out_val);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    feed(8'h01, 8);
    feed(8'h03, 5);
    checks++;
    if (out_valid !== 1'b1 || count !== 3'd5) begin
      errors++;
      $display("FAIL rstmid_pre: out_valid=%b count=%0d, want 1 5", out_valid, count);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_val !== 11'h000 || count !== 3'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: out_valid=%b out_val=%h count=%0d in_ready=%b, want 0 000 0 0",
               out_valid, out_val, count, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    feed(8'h02, 8);
    checks++;
    if (out_valid !== 1'b1 || out_val !== 11'h010) begin
      errors++;
      $display("FAIL rstmid_sum: out_valid=%b out_val=%h, want 1 010", out_valid, out_val);
    end
    @(negedge clk);
  endtask

  task automatic test_n1;
    logic [7:0]  vin  [3];
    logic [10:0] vout [3];
    vin[0] = 8'h03; vin[1] = 8'hFC; vin[2] = 8'h7F;
    vout[0] = 11'h003; vout[1] = 11'h7FC; vout[2] = 11'h07F;
    out_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_valid1 !== 1'b1 || out_val1 !== vout[i-1] || count1 !== 1'b0) begin
          errors++;
          $display("FAIL n1_out%0d: out_valid=%b out_val=%h count=%0d, want 1 %h 0",
                   i - 1, out_valid1, out_val1, count1, vout[i-1]);
        end
      end
      if (i < 3) begin
        in_valid1 = 1'b1;
        in_val1   = vin[i];
      end else begin
        in_valid1 = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid1 !== 1'b0 || out_val1 !== 11'h07F) begin
      errors++;
      $display("FAIL n1_drain: out_valid=%b out_val=%h, want 0 07f", out_valid1, out_val1);
    end
  endtask

  task automatic test_random;
    logic [10:0] q[$];
    logic [10:0] exp;
    logic [10:0] hval;
    logic [7:0]  cur;
    logic        hold;
    int sent, dumps, cyc, sum, k;
    sent = 0; dumps = 0; cyc = 0; sum = 0; k = 0; hold = 1'b0; hval = '0;
    cur = 8'($urandom);
    while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_val !== hval) begin
          errors++;
          $display("FAIL rnd_hold cyc %0d: out_valid=%b out_val=%h, want 1 %h", cyc, out_valid, out_val, hval);
        end
      end
      in_val    = cur;
      in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        dumps++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra cyc %0d: unexpected sum %h", cyc, out_val);
        end else begin
          exp = q.pop_front();
          if (out_val !== exp) begin
            errors++;
            $display("FAIL rnd_sum %0d: out_val=%h, want %h", dumps, out_val, exp);
          end
        end
      end
      hold = out_valid && !out_ready;
      hval = out_val;
      if (in_valid && in_ready) begin
        sum += int'($signed(in_val));
        k++;
        sent++;
        if (k == 8) begin
          q.push_back(11'(sum));
          sum = 0;
          k = 0;
        end
        cur = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (dumps != 1250 || q.size() != 0 || cyc >= 60000) begin
      errors++;
      $display("FAIL rnd_total: dumps=%0d pending=%0d cycles=%0d, want 1250 0 <60000", dumps, q.size(), cyc);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_val = '0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    in_val1 = '0; in_valid1 = 1'b0; clear1 = 1'b0; out_ready1 = 1'b0;
    test_reset;
    test_basic_sum;
    test_backpressure;
    test_clear;
    test_reset_mid;
    test_n1;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfp_accum_dump.md
Name: sfp_accum_dump

Overview:
- Integrate-and-dump accumulator for signed fixed-point streams; sits directly upstream of sfp_resize / sfp_resize_ind.
- Sums N consecutive valid-qualified sfp input samples at full precision and emits the sum as one wide sfp output sample with valid/ready handshake.
- A downstream resize stage then narrows the wide sum to the working format (truncate LSBs, clip or wrap MSBs).

Parameters:
- N, 8, number of input samples per dump; N >= 1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in  sfp.in  fp_wl(in)  input sample; in.val is signed, format iniw.inqw.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept input this cycle.
- clear  input  1  synchronous discard of the partial sum.
- out  sfp.out  fp_wl(out)  dumped sum; format outiw.outqw.
- out_valid  output  1  out.val holds an unconsumed sum.
- out_ready  input  1  downstream accepts out this cycle.
- count  output  max(1,$clog2(N))  samples accumulated in the current block (0..N-1).

Behaviour:
- Elaboration checks, each $error on violation:
  - outqw == inqw.
  - outiw >= iniw + $clog2(N).
  - Together these make overflow impossible, so there is no clipping logic.
- State:
  - acc, signed, fp_wl(out) bits.
  - count, 0..N-1.
  - Output register out.val / out_valid.
- Reset (async assert, sync-safe deassert): acc=0, count=0, out.val=0, out_valid=0. in_ready=0 while rst is high.
- Input enable:
  - in_ready = !clear && (count != N-1 || !out_valid || out_ready).
  - Only the sample that completes a block stalls against a held output. Non-final samples are always accepted.
- Accept = in_valid && in_ready. The input is sign-extended to fp_wl(out) before the add.
- On accept with count < N-1: acc <= acc + in; count <= count+1.
- On accept with count == N-1:
  - out.val <= acc + in; out_valid <= 1.
  - acc <= 0; count <= 0.
- Latency: out_valid rises on the cycle after the Nth sample is accepted.
- Throughput: one sample per cycle sustained when out_ready is held high.
- Output handshake:
  - out_valid && out_ready consumes the sum.
  - If no new dump occurs in the same cycle, out_valid <= 0 and out.val holds its last value.
  - A dump in the same cycle as consumption reloads out.val and keeps out_valid=1, with no bubble.
- Held output: while out_valid && !out_ready, out.val is stable and out_valid stays 1.
- clear:
  - acc <= 0, count <= 0.
  - in_ready is forced 0, so no sample is accepted or lost in that cycle.
  - The output register and out_valid are unaffected.
  - clear when count==0 has no visible effect.
- N == 1: every accepted sample is registered straight to out (acc stays 0). count is a 1-bit constant 0.
- Sums wrap nowhere; two's-complement arithmetic throughout.

Test Plan:
- Format in 1.7 (8b), out 4.7 (11b), N=8, out_ready=1:
  - Eight samples of 0x7F -> one cycle after the 8th accept, out_valid=1 and out.val=1016 (0x3F8).
  - Then eight samples of 0x80 -> out.val=-1024 (0x400). Each out_valid lasts exactly one cycle.
- Backpressure, out_ready=0, 16 back-to-back samples of 1:
  - First sum (8) is held with out_valid=1.
  - Samples 9-15 are accepted; in_ready=0 on the 16th with count=7.
  - Raise out_ready -> first sum consumed that cycle, 16th sample accepted, next cycle out.val=8 and out_valid=1.
- Clear mid-block:
  - Accept 3 samples of 5, assert clear for one cycle -> in_ready=0 and count=0 next cycle.
  - Then 8 samples of 1 -> out.val=8.
- Reset mid-operation:
  - Assert rst after 5 samples and while an output is held -> immediately out_valid=0, out.val=0, count=0, in_ready=0.
  - After release, 8 samples of 2 -> out.val=16.
- N=1, same formats:
  - Samples 3, -4, 127 with in_valid=1 every cycle -> out.val=3, -4, 127 on consecutive cycles, one cycle after each accept.
  - out_valid stays 1 continuously.
- Random in_valid/out_ready, 10k samples, N=8, compared against a reference-model block sum:
  - All sums match.
  - No sample is dropped or duplicated.
  - out.val is stable whenever out_valid && !out_ready.
